mplist_mem_rd_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares the single memory read port (mem_rd_req/mem_rd_gnt) among NUM_REQ message-path requesters, such as the msg_req/msg_resp children.
- Accepts one request at a time and drives the memory request/grant handshake.
- Waits the fixed memory read latency, then returns the read data to the winning requester with a one-cycle response pulse.
- Sits between the message children and the memory read port; exactly one read is outstanding at any time.

---
 rtl/mplist_mem_rd_arb.sv | 167 ++++++++++++++++
 tb/tb_mplist_mem_rd_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mplist_mem_rd_arb.sv
`timescale 1ns/1ps
// mplist_mem_rd_arb: round-robin arbiter sharing the single memory read port
// among NUM_REQ message-path requesters. One read in flight at a time; the
// read data comes back to the winner as a one-cycle response pulse after the
// fixed memory read latency.
module mplist_mem_rd_arb #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RD_LAT  = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      mem_rd_req,
   output logic [ADDR_W-1:0]         mem_rd_addr,
   input  logic                      mem_rd_gnt,
   input  logic [DATA_W-1:0]         mem_rd_data,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      msg_busy
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      RSP
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [IDX_W-1:0]     rr_ptr;
   logic [IDX_W-1:0]     win_q;
   logic [LAT_W-1:0]     lat_cnt;
   logic [ADDR_W-1:0]    addr_q;

   logic                 pick_found;
   logic [IDX_W-1:0]     pick_idx;
   logic [IDX_W-1:0]     pick_nxt_ptr;
   logic [NUM_REQ-1:0]   pick_onehot;
   logic [ADDR_W-1:0]    pick_addr;
   logic [NUM_REQ-1:0]   win_onehot;
   int unsigned          cand;
   logic [IDX_W-1:0]     cand_idx;

   assign mem_rd_addr = addr_q;
   assign msg_busy    = (state != IDLE);

   // Round-robin search: first valid requester at or above rr_ptr, wrapping.
   always_comb begin
      pick_found   = 1'b0;
      pick_idx     = '0;
      pick_nxt_ptr = '0;
      cand         = 0;
      cand_idx     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand     = (32'(rr_ptr) + k) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!pick_found && req_valid[cand_idx]) begin
            pick_found   = 1'b1;
            pick_idx     = cand_idx;
            pick_nxt_ptr = IDX_W'((cand + 1) % NUM_REQ);
         end
      end
   end

   // Decode the picked and stored winner indices into one-hot masks and the winning address.
   always_comb begin
      pick_onehot = '0;
      win_onehot  = '0;
      pick_addr   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         pick_onehot[i] = pick_found && (pick_idx == IDX_W'(i));
         win_onehot[i]  = (win_q == IDX_W'(i));
         if (pick_idx == IDX_W'(i)) begin
            pick_addr = req_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and the combinational acceptance pulse.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_nxt = REQ;
               req_ready = pick_onehot;
            end
         end
         REQ: begin
            if (mem_rd_gnt) begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt == '0) begin
               state_nxt = RSP;
            end
         end
         RSP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: capture the winner, drive the memory handshake, count latency, return data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr     <= '0;
         win_q      <= '0;
         lat_cnt    <= '0;
         addr_q     <= '0;
         mem_rd_req <= 1'b0;
         rsp_valid  <= '0;
         rsp_data   <= '0;
      end else begin
         rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  addr_q     <= pick_addr;
                  win_q      <= pick_idx;
                  rr_ptr     <= pick_nxt_ptr;
                  mem_rd_req <= 1'b1;
               end
            end
            REQ: begin
               if (mem_rd_gnt) begin
                  mem_rd_req <= 1'b0;
                  lat_cnt    <= LAT_W'(RD_LAT - 1);
               end
            end
            WAIT: begin
               if (lat_cnt == '0) begin
                  rsp_data  <= mem_rd_data;
                  rsp_valid <= win_onehot;
               end else begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mplist_mem_rd_arb.sv
`timescale 1ns/1ps
// Bench for mplist_mem_rd_arb: a 4-requester RD_LAT=2 instance driven by a
// table of arbitration cases plus hand-written sequences, and a 2-requester
// RD_LAT=1 instance for the short-latency build. Responses are checked
// against a scoreboard filled at each acceptance.
module tb_mplist_mem_rd_arb;

   localparam int unsigned NREQ = 4;
   localparam int unsigned AW   = 16;
   localparam int unsigned DW   = 32;
   localparam int unsigned LAT  = 2;

   logic              clk     = 1'b0;
   logic              reset_n = 1'b1;

   logic [NREQ-1:0]    req_valid = '0;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ-1:0]    req_ready;
   logic               mem_rd_req;
   logic [AW-1:0]      mem_rd_addr;
   logic               mem_rd_gnt;
   logic [DW-1:0]      mem_rd_data;
   logic [NREQ-1:0]    rsp_valid;
   logic [DW-1:0]      rsp_data;
   logic               msg_busy;

   logic [1:0]         req_valid1 = '0;
   logic [2*AW-1:0]    req_addr1;
   logic [1:0]         req_ready1;
   logic               mem_rd_req1;
   logic [AW-1:0]      mem_rd_addr1;
   logic               mem_rd_gnt1;
   logic [DW-1:0]      mem_rd_data1;
   logic [1:0]         rsp_valid1;
   logic [DW-1:0]      rsp_data1;
   logic               msg_busy1;

   always #5 clk = ~clk;

   mplist_mem_rd_arb #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
      .mem_rd_gnt(mem_rd_gnt), .mem_rd_data(mem_rd_data), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .msg_busy(msg_busy)
   );

   mplist_mem_rd_arb #(.NUM_REQ(2), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid1), .req_addr(req_addr1),
      .req_ready(req_ready1), .mem_rd_req(mem_rd_req1), .mem_rd_addr(mem_rd_addr1),
      .mem_rd_gnt(mem_rd_gnt1), .mem_rd_data(mem_rd_data1), .rsp_valid(rsp_valid1),
      .rsp_data(rsp_data1), .msg_busy(msg_busy1)
   );

   function automatic logic [31:0] memf(input logic [15:0] a);
      if (a == 16'h1234) return 32'hDEAD_BEEF;
      return {a ^ 16'hC3A5, ~a};
   endfunction

   // Memory model for the RD_LAT=2 instance: grant after gnt_dly stalled cycles, data RD_LAT later.
   int unsigned gnt_dly   = 0;
   logic        stray_gnt = 1'b0;
   int unsigned stall_cnt = 0;
   logic [1:0]  pv        = '0;
   logic [15:0] pa0       = '0;
   logic [15:0] pa1       = '0;

   assign mem_rd_gnt  = stray_gnt | (mem_rd_req && (stall_cnt >= gnt_dly));
   assign mem_rd_data = pv[1] ? memf(pa1) : 32'hBAD0_0BAD;

   always @(posedge clk) begin
      if (!mem_rd_req || mem_rd_gnt) stall_cnt <= 0;
      else                           stall_cnt <= stall_cnt + 1;
      pv  <= {pv[0], mem_rd_req & mem_rd_gnt};
      pa1 <= pa0;
      pa0 <= mem_rd_addr;
   end

   // Memory model for the RD_LAT=1 instance: immediate grant, data one cycle later.
   logic        pv1  = 1'b0;
   logic [15:0] pa_1 = '0;

   assign mem_rd_gnt1  = mem_rd_req1;
   assign mem_rd_data1 = pv1 ? memf(pa_1) : 32'hBAD1_1BAD;

   always @(posedge clk) begin
      pv1  <= mem_rd_req1 & mem_rd_gnt1;
      pa_1 <= mem_rd_addr1;
   end

   typedef struct {
      int unsigned idx;
      logic [31:0] data;
   } sb_t;

   typedef struct {
      logic [3:0]  valid;
      int unsigned gd;
      logic [3:0]  exp_ready;
   } row_t;

   sb_t         sb_q[$];
   row_t        rows[8];
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned ncyc   = 0;
   int unsigned model_ptr = 0;

   logic [NREQ-1:0] s_ready, s_rsp;
   logic            s_mreq, s_gnt, s_busy;
   logic [AW-1:0]   s_maddr;
   logic [DW-1:0]   s_rdata;
   logic [1:0]      s1_ready, s1_rsp;
   logic            s1_mreq, s1_busy;
   logic [AW-1:0]   s1_maddr;
   logic [DW-1:0]   s1_rdata;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int unsigned model_pick(input logic [3:0] v, input int unsigned p);
      for (int unsigned k = 0; k < NREQ; k++) begin
         int unsigned c = (p + k) % NREQ;
         if (v[c]) return c;
      end
      return NREQ;
   endfunction

   // Sample one cycle mid-period, run the scoreboard, then advance past the next rising edge.
   task automatic step();
      int unsigned exp_w;
      sb_t e;
      @(negedge clk);
      ncyc++;
      s_ready = req_ready;   s_rsp = rsp_valid;     s_mreq = mem_rd_req;
      s_gnt = mem_rd_gnt;    s_busy = msg_busy;     s_maddr = mem_rd_addr;
      s_rdata = rsp_data;
      s1_ready = req_ready1; s1_rsp = rsp_valid1;   s1_mreq = mem_rd_req1;
      s1_busy = msg_busy1;   s1_maddr = mem_rd_addr1; s1_rdata = rsp_data1;
      if (req_ready != '0) begin
         exp_w = model_pick(req_valid, model_ptr);
         check("rr_pick", 64'(req_ready), 64'd1 << exp_w);
         if (exp_w < NREQ) begin
            e.idx  = exp_w;
            e.data = memf(req_addr[exp_w*AW +: AW]);
            sb_q.push_back(e);
            model_ptr = (exp_w + 1) % NREQ;
         end
      end
      if (rsp_valid != '0) begin
         if (sb_q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("rsp_idx", 64'(rsp_valid), 64'd1 << e.idx);
            check("rsp_data", 64'(rsp_data), 64'(e.data));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int unsigned n = 0;
      while (msg_busy && n < 40) begin
         step();
         n++;
      end
      check("idle_timeout", 64'(msg_busy), 64'd0);
   endtask

   task automatic wait_rsp(output int unsigned at);
      int unsigned n = 0;
      at = 0;
      do begin
         step();
         n++;
      end while (s_rsp == '0 && n < 40);
      at = ncyc;
      check("rsp_timeout", 64'(s_rsp != '0), 64'd1);
   endtask

   initial begin
      int unsigned t, g, cnt, idx;
      int unsigned acc_idx[5];
      int unsigned acc_cyc[5];
      int unsigned exp_order[5];

      req_addr  = {16'h3C33, 16'h1234, 16'h0B11, 16'h0A00};
      req_addr1 = {16'h5A5A, 16'h0707};
      exp_order = '{0, 1, 2, 3, 0};
      // rr_ptr enters the table at 3 after the single read to requester 2
      rows[0] = '{4'b0101, 0, 4'b0001};
      rows[1] = '{4'b0101, 1, 4'b0100};
      rows[2] = '{4'b1000, 3, 4'b1000};
      rows[3] = '{4'b0010, 0, 4'b0010};
      rows[4] = '{4'b0011, 2, 4'b0001};
      rows[5] = '{4'b1100, 0, 4'b0100};
      rows[6] = '{4'b1111, 1, 4'b1000};
      rows[7] = '{4'b1010, 0, 4'b0010};

      // Reset values
      #2 reset_n = 1'b0;
      #10;
      check("rst_ready",  64'(req_ready),   64'd0);
      check("rst_mreq",   64'(mem_rd_req),  64'd0);
      check("rst_maddr",  64'(mem_rd_addr), 64'd0);
      check("rst_rsp",    64'(rsp_valid),   64'd0);
      check("rst_rdata",  64'(rsp_data),    64'd0);
      check("rst_busy",   64'(msg_busy),    64'd0);
      check("rst_busy1",  64'(msg_busy1),   64'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Single read to requester 2
      req_valid = 4'b0100;
      step();
      check("t1_ready", 64'(s_ready), 64'h4);
      req_valid = '0;
      step();
      check("t1_mreq", 64'(s_mreq), 64'd1);
      check("t1_maddr", 64'(s_maddr), 64'h1234);
      check("t1_busy", 64'(s_busy), 64'd1);
      step();
      check("t1_mreq_drop", 64'(s_mreq), 64'd0);
      step();
      check("t1_rsp_early", 64'(s_rsp), 64'd0);
      step();
      check("t1_rsp", 64'(s_rsp), 64'h4);
      check("t1_rdata", 64'(s_rdata), 64'hDEAD_BEEF);
      step();
      check("t1_idle", 64'(s_busy), 64'd0);
      check("t1_rsp_once", 64'(s_rsp), 64'd0);

      // Arbitration table: wrap, skip and mixed grant delays
      foreach (rows[r]) begin
         wait_idle();
         gnt_dly   = rows[r].gd;
         req_valid = rows[r].valid;
         step();
         check("tbl_ready", 64'(s_ready), 64'(rows[r].exp_ready));
         req_valid = '0;
         wait_rsp(t);
      end
      gnt_dly = 0;

      // Grant stall of 7 cycles, then a stray grant during WAIT
      wait_idle();
      gnt_dly   = 7;
      req_valid = 4'b0010;
      step();
      check("stall_ready", 64'(s_ready), 64'h2);
      req_valid = '0;
      for (int k = 0; k < 7; k++) begin
         step();
         check("stall_mreq", 64'(s_mreq), 64'd1);
         check("stall_maddr", 64'(s_maddr), 64'h0B11);
      end
      step();
      check("stall_gnt", 64'(s_mreq & s_gnt), 64'd1);
      g = ncyc;
      gnt_dly   = 0;
      stray_gnt = 1'b1;
      step();
      stray_gnt = 1'b0;
      wait_rsp(t);
      check("stall_rsp_lat", 64'(t - g), 64'(LAT + 1));
      for (int k = 0; k < 6; k++) begin
         step();
         check("stray_no_rsp", 64'(s_rsp), 64'd0);
      end

      // Reset while in WAIT abandons the read
      wait_idle();
      req_valid = 4'b0001;
      step();
      check("r5_ready", 64'(s_ready), 64'h1);
      req_valid = '0;
      step();
      step();
      reset_n = 1'b0;
      #1;
      check("r5_mreq",  64'(mem_rd_req),  64'd0);
      check("r5_maddr", 64'(mem_rd_addr), 64'd0);
      check("r5_rsp",   64'(rsp_valid),   64'd0);
      check("r5_rdata", 64'(rsp_data),    64'd0);
      check("r5_busy",  64'(msg_busy),    64'd0);
      sb_q.delete();
      model_ptr = 0;
      step();
      reset_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         check("r5_no_rsp", 64'(s_rsp), 64'd0);
      end

      // Round-robin with all requesters held: order 0,1,2,3,0 five cycles apart
      acc_idx = '{99, 99, 99, 99, 99};
      acc_cyc = '{0, 0, 0, 0, 0};
      cnt = 0;
      req_valid = 4'b1111;
      for (int n = 0; n < 40 && cnt < 5; n++) begin
         step();
         if (s_ready != '0) begin
            idx = 99;
            for (int i = NREQ - 1; i >= 0; i--) if (s_ready[i]) idx = i;
            acc_idx[cnt] = idx;
            acc_cyc[cnt] = ncyc;
            cnt++;
         end
      end
      req_valid = '0;
      for (int i = 0; i < 5; i++) check("rr_order", 64'(acc_idx[i]), 64'(exp_order[i]));
      for (int i = 1; i < 5; i++) check("rr_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(LAT + 3));
      wait_idle();
      check("sb_drained", 64'(sb_q.size()), 64'd0);

      // RD_LAT=1 build: data captured at G+1, response at G+2
      req_valid1 = 2'b10;
      step();
      check("l1_ready", 64'(s1_ready), 64'h2);
      req_valid1 = '0;
      step();
      check("l1_mreq", 64'(s1_mreq), 64'd1);
      check("l1_maddr", 64'(s1_maddr), 64'h5A5A);
      step();
      check("l1_rsp_early", 64'(s1_rsp), 64'd0);
      step();
      check("l1_rsp", 64'(s1_rsp), 64'h2);
      check("l1_rdata", 64'(s1_rdata), 64'(memf(16'h5A5A)));
      step();
      check("l1_idle", 64'(s1_busy), 64'd0);
      req_valid1 = 2'b11;
      step();
      check("l1_wrap", 64'(s1_ready), 64'h1);
      req_valid1 = '0;
      for (int k = 0; k < 6; k++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
